// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int          DIV_ITER      = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  localparam int RES_REM_MSB = 63;
  localparam int RES_REM_LSB = 32;
  localparam int RES_QUO_MSB = 31;
  localparam int RES_QUO_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negation of a {R, Q} pair.
// Used both for operand magnitudes and for the final sign correction.
`default_nettype none

module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_q,
  input  logic [WIDTH-1:0]   i_r,
  input  logic               i_q_neg,
  input  logic               i_r_neg,
  output logic [2*WIDTH-1:0] o_res
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_q   = i_q_neg ? (~i_q + 1'b1) : i_q;
  assign w_r   = i_r_neg ? (~i_r + 1'b1) : i_r;
  assign o_res = {w_r, w_q};

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// div_seq: 32-bit sequential non-restoring divider, one quotient bit per cycle.
// result = {remainder, quotient}; divide-by-zero returns {dividend, all-ones}.
`default_nettype none

module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int               CNT_W    = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [2*WIDTH-1:0] r_result;

  logic [2*WIDTH-1:0] w_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_rem_next;
  logic [WIDTH-1:0]   w_rem_fixed;
  logic [2*WIDTH-1:0] w_fix;

  div_sign_fix #(.WIDTH(WIDTH)) u_mag (
    .i_q     (dividend),
    .i_r     (divisor),
    .i_q_neg (is_signed & dividend[WIDTH-1]),
    .i_r_neg (is_signed & divisor[WIDTH-1]),
    .o_res   (w_mag)
  );

  // Modulo-2^(WIDTH+1) arithmetic is exact here: |R| stays below D after every step.
  assign w_shift     = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_rem_next  = r_rem[WIDTH] ? (w_shift + {1'b0, r_dvs})
                                    : (w_shift - {1'b0, r_dvs});
  assign w_rem_fixed = r_rem[WIDTH-1:0] + (r_rem[WIDTH] ? r_dvs : '0);

  div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_q     (r_quo),
    .i_r     (w_rem_fixed),
    .i_q_neg (r_qneg),
    .i_r_neg (r_rneg),
    .o_res   (w_fix)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_dbz  <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_qneg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_rneg <= is_signed & dividend[WIDTH-1];
            r_quo  <= w_mag[WIDTH-1:0];
            r_dvs  <= w_mag[2*WIDTH-1:WIDTH];
            if (divisor == '0) begin
              r_dbz    <= 1'b1;
              r_result <= {dividend, DIV_ZERO_QUOT};
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], ~w_rem_next[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= w_fix;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign result      = r_result;

endmodule

`default_nettype wire
